square_root_seq: RTL

Sequential integer square-root unit: the inverse path of the 4-bit square lookup. It accepts an unsigned square value and returns the non-negative floor root, one root bit per clock, with a start/ready/done handshake. It sits downstream of any block producing squared magnitudes and recovers the magnitude; sign is not recoverable from a square, so the root is always non-negative.

---
 rtl/square_root_seq_if.sv | 21 ++
 rtl/square_root_seq.sv | 119 +++++++++++
 2 files changed

// File: rtl/square_root_seq_if.sv
// Handshake/data bundle for square_root_seq.
// The remainder signal exists only when SQRT_REM_EN is defined.
interface square_root_seq_if #(
    parameter int IN_W = 8
);
    logic                start;
    logic [IN_W-1:0]     square;
    logic                ready;
    logic                done;
    logic [IN_W/2-1:0]   root;
    logic                exact;
`ifdef SQRT_REM_EN
    logic [IN_W/2:0]     rem;

    modport master (output start, square, input  ready, done, root, exact, rem);
    modport slave  (input  start, square, output ready, done, root, exact, rem);
`else
    modport master (output start, square, input  ready, done, root, exact);
    modport slave  (input  start, square, output ready, done, root, exact);
`endif
endinterface

// File: rtl/square_root_seq.sv
// Sequential integer square root, restoring digit-by-digit, one root bit
// per clock, MSB first. start/ready/done handshake through square_root_seq_if.
// Optional macro SQRT_REM_EN: exposes the final remainder on the rem port.
module square_root_seq #(
    parameter int IN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    square_root_seq_if.slave  bus
);
    localparam int H  = IN_W / 2;          // root width
    localparam int RW = H + 2;             // partial remainder, wide enough pre-subtract
    localparam int CW = (H > 1) ? $clog2(H) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [IN_W-1:0] op_q, op_d;           // operand, consumed two bits per step from the top
    logic [H-1:0]    root_p_q, root_p_d;
    logic [RW-1:0]   rem_p_q, rem_p_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [H-1:0]    root_q, root_d;
    logic            exact_q, exact_d;
`ifdef SQRT_REM_EN
    logic [H:0]      rem_q, rem_d;
`endif

    logic [RW-1:0]   rem_t, trial, rem_n;
    logic            bit_n;
    logic [H-1:0]    root_n;

    // State and datapath registers; reset drops any in-flight result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            root_p_q <= '0;
            rem_p_q  <= '0;
            cnt_q    <= '0;
            root_q   <= '0;
            exact_q  <= 1'b0;
`ifdef SQRT_REM_EN
            rem_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            root_p_q <= root_p_d;
            rem_p_q  <= rem_p_d;
            cnt_q    <= cnt_d;
            root_q   <= root_d;
            exact_q  <= exact_d;
`ifdef SQRT_REM_EN
            rem_q    <= rem_d;
`endif
        end
    end

    // One restoring step plus next-state decode
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        root_p_d = root_p_q;
        rem_p_d  = rem_p_q;
        cnt_d    = cnt_q;
        root_d   = root_q;
        exact_d  = exact_q;
`ifdef SQRT_REM_EN
        rem_d    = rem_q;
`endif
        // Bring down the next two operand bits and try root*4+1
        rem_t = (rem_p_q << 2) | RW'(op_q[IN_W-1 -: 2]);
        trial = (RW'(root_p_q) << 2) | RW'(1);
        if (rem_t >= trial) begin
            rem_n = rem_t - trial;
            bit_n = 1'b1;
        end else begin
            rem_n = rem_t;
            bit_n = 1'b0;
        end
        root_n = (root_p_q << 1) | H'(bit_n);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d     = bus.square;
                    root_p_d = '0;
                    rem_p_d  = '0;
                    cnt_d    = CW'(H - 1);
                    state_d  = CALC;
                end
            end
            CALC: begin
                op_d     = op_q << 2;
                root_p_d = root_n;
                rem_p_d  = rem_n;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    root_d  = root_n;
                    exact_d = (rem_n == '0);
`ifdef SQRT_REM_EN
                    rem_d   = rem_n[H:0];
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.root  = root_q;
    assign bus.exact = exact_q;
`ifdef SQRT_REM_EN
    assign bus.rem   = rem_q;
`endif
endmodule
